// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the streaming population counter.
// Any block that sizes a bit count from a vector width uses cnt_w.
package popcount_pkg;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_ACCUM  = 1'b1
  } pc_mode_t;

  // Bits needed to hold a count of 0..w set bits.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/popcount_stream_if.sv
// Input beat and output result handshakes of popcount_stream, bundled as one bus.
// slave is the counter's view of the bus; master is the view of whatever drives it.
interface popcount_stream_if #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_count;
  logic             out_sat;

  modport master (
    output in_valid, in_data, in_last, in_mode, out_ready,
    input  in_ready, out_valid, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, in_mode, out_ready,
    output in_ready, out_valid, out_count, out_sat
  );
endinterface

// File: rtl/popcount_lane.sv
// Combinational population count of one LANE-bit slice of an input beat.
// The adder chain is left to synthesis to rebalance into a full-adder tree.
module popcount_lane
  import popcount_pkg::*;
#(
  parameter int LANE = 8
) (
  input  logic [LANE-1:0]            i_bits,
  output logic [$clog2(LANE+1)-1:0]  o_cnt
);
  localparam int CW = cnt_w(LANE);

  always_comb begin
    o_cnt = '0;
    for (int b = 0; b < LANE; b++) begin
      o_cnt = o_cnt + CW'(i_bits[b]);
    end
  end
endmodule

// File: rtl/popcount_stream.sv
// Two-stage streaming popcount: lane counts registered in stage 1, lane sum plus
// frame accumulation with saturation in stage 2; valid/ready on both sides.
module popcount_stream
  import popcount_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANE  = 8,
  parameter int ACC_W = 16
) (
  input  logic              CLK,
  input  logic              ASYNCRESETN,
  popcount_stream_if.slave  bus
);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam int NL    = WIDTH / LANE;
  localparam int LW    = cnt_w(LANE);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  if ((WIDTH % LANE) != 0) begin : g_bad_lane
    $error("popcount_stream: WIDTH must be a multiple of LANE");
  end
  if (ACC_W < CNT_W) begin : g_bad_acc
    $error("popcount_stream: ACC_W too narrow for one beat count");
  end

  logic [LW-1:0]    w_lane_cnt [NL];
  logic [LW-1:0]    r_lane_cnt [NL];
  logic             r_s1_valid;
  logic             r_s1_last;
  pc_mode_t         r_s1_mode;
  logic [ACC_W-1:0] r_acc;
  logic             r_acc_sat;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_count;
  logic             r_out_sat;

  logic             w_adv2;
  logic             w_accept;
  logic [CNT_W-1:0] w_sum;
  logic [ACC_W:0]   w_acc_sum;
  logic             w_clamp;
  logic [ACC_W-1:0] w_acc_clamped;

  genvar gi;
  for (gi = 0; gi < NL; gi++) begin : g_lane
    popcount_lane #(.LANE(LANE)) u_lane (
      .i_bits (bus.in_data[gi*LANE +: LANE]),
      .o_cnt  (w_lane_cnt[gi])
    );
  end

  // Stage 2 may move whenever the output register is empty or being drained.
  assign w_adv2   = !r_out_valid || bus.out_ready;
  assign w_accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !r_s1_valid || w_adv2;
  assign bus.out_valid = r_out_valid;
  assign bus.out_count = r_out_count;
  assign bus.out_sat   = r_out_sat;

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_lane_cnt <= w_lane_cnt;
      r_s1_mode  <= pc_mode_t'(bus.in_mode);
      r_s1_last  <= bus.in_last;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NL; k++) begin
      w_sum = w_sum + CNT_W'(r_lane_cnt[k]);
    end
  end

  // One extra bit catches overflow; acc <= ACC_MAX and sum <= WIDTH so it never wraps.
  assign w_acc_sum     = {1'b0, r_acc} + (ACC_W+1)'(w_sum);
  assign w_clamp       = w_acc_sum[ACC_W];
  assign w_acc_clamped = w_clamp ? ACC_MAX : w_acc_sum[ACC_W-1:0];

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_s1_valid  <= 1'b0;
      r_acc       <= '0;
      r_acc_sat   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
      end else if (w_adv2) begin
        r_s1_valid <= 1'b0;
      end

      if (w_adv2) begin
        r_out_valid <= 1'b0;
        if (r_s1_valid) begin
          if (r_s1_mode == MODE_SINGLE) begin
            r_out_valid <= 1'b1;
            r_out_count <= ACC_W'(w_sum);
            r_out_sat   <= 1'b0;
          end else if (!r_s1_last) begin
            r_acc     <= w_acc_clamped;
            r_acc_sat <= r_acc_sat | w_clamp;
          end else begin
            r_out_valid <= 1'b1;
            r_out_count <= w_acc_clamped;
            r_out_sat   <= r_acc_sat | w_clamp;
            r_acc       <= '0;
            r_acc_sat   <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_popcount_stream.sv
// Self-checking bench: two counters (ACC_W=16 and ACC_W=6) share one stimulus and are
// compared against a frame-level scoreboard built from plain bit counts and totals.
module tb_popcount_stream;

  localparam int MAX_A = 65535;
  localparam int MAX_B = 63;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  popcount_stream_if #(.WIDTH(32), .ACC_W(16)) ia ();
  popcount_stream_if #(.WIDTH(32), .ACC_W(6))  ib ();

  assign ib.in_valid  = ia.in_valid;
  assign ib.in_data   = ia.in_data;
  assign ib.in_last   = ia.in_last;
  assign ib.in_mode   = ia.in_mode;
  assign ib.out_ready = ia.out_ready;

  popcount_stream #(.WIDTH(32), .LANE(8), .ACC_W(16)) u_dut_a (
    .CLK(clk), .ASYNCRESETN(rst_n), .bus(ia)
  );
  popcount_stream #(.WIDTH(32), .LANE(8), .ACC_W(6)) u_dut_b (
    .CLK(clk), .ASYNCRESETN(rst_n), .bus(ib)
  );

  typedef struct {
    int due;
    int ca;
    bit sa;
    int cb;
    bit sb;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    int          cnt;
  } vec_t;

  exp_t q[$];
  int   acc_tot = 0;
  int   idx     = 0;
  int   n_chk   = 0;
  int   n_err   = 0;
  bit   chk_lat = 0;
  bit   held    = 0;
  int   held_ca, held_cb;
  bit   held_sa, held_sb;
  bit   s_ov, s_rdy, s_fired;
  int   s_ca, s_cb;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, idx, act, exp);
    end
  endtask

  // Reference model: a frame total is the plain sum of its beats' bit counts, clamped.
  task automatic push_beat(input logic [31:0] d, input logic m, input logic l);
    int   c;
    exp_t e;
    c = $countones(d);
    if (!m) begin
      e.due = idx + 2; e.ca = c; e.sa = 0; e.cb = c; e.sb = 0;
      q.push_back(e);
    end else begin
      acc_tot += c;
      if (l) begin
        e.due = idx + 2;
        e.ca  = (acc_tot > MAX_A) ? MAX_A : acc_tot;
        e.sa  = (acc_tot > MAX_A);
        e.cb  = (acc_tot > MAX_B) ? MAX_B : acc_tot;
        e.sb  = (acc_tot > MAX_B);
        q.push_back(e);
        acc_tot = 0;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic m,
                     input logic l, input logic ordy);
    ia.in_valid  = v;
    ia.in_data   = d;
    ia.in_mode   = m;
    ia.in_last   = l;
    ia.out_ready = ordy;
    #1;
    s_ov  = ia.out_valid;
    s_ca  = int'(ia.out_count);
    s_cb  = int'(ib.out_count);
    s_rdy = ia.in_ready;
    if (held) begin
      chk("hold_valid_a", ia.out_valid, 1);
      chk("hold_count_a", ia.out_count, held_ca);
      chk("hold_sat_a",   ia.out_sat,   held_sa);
      chk("hold_valid_b", ib.out_valid, 1);
      chk("hold_count_b", ib.out_count, held_cb);
      chk("hold_sat_b",   ib.out_sat,   held_sb);
    end
    if (ia.out_valid || ib.out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid_a", ia.out_valid, 0);
        chk("spurious_valid_b", ib.out_valid, 0);
      end else begin
        chk("valid_a", ia.out_valid, 1);
        chk("valid_b", ib.out_valid, 1);
        if (chk_lat && !held) chk("latency", idx, q[0].due);
        if (ordy) begin
          chk("count_a", ia.out_count, q[0].ca);
          chk("sat_a",   ia.out_sat,   q[0].sa);
          chk("count_b", ib.out_count, q[0].cb);
          chk("sat_b",   ib.out_sat,   q[0].sb);
          void'(q.pop_front());
        end
      end
    end else if (chk_lat && q.size() > 0 && q[0].due == idx) begin
      chk("late_valid", ia.out_valid, 1);
    end
    held    = ia.out_valid && !ordy;
    held_ca = int'(ia.out_count); held_sa = ia.out_sat;
    held_cb = int'(ib.out_count); held_sb = ib.out_sat;
    s_fired = v && ia.in_ready;
    if (s_fired) push_beat(d, m, l);
    @(posedge clk);
    #1;
    idx++;
  endtask

  task automatic drain();
    repeat (4) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("queue_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    ia.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid_a",  ia.out_valid, 0);
    chk("rst_valid_b",  ib.out_valid, 0);
    chk("rst_count_a",  ia.out_count, 0);
    chk("rst_sat_b",    ib.out_sat,   0);
    chk("rst_in_ready", ia.in_ready,  1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    acc_tot = 0;
    held    = 0;
    idx++;
  endtask

  vec_t tbl [8];
  logic [31:0] beats [5];
  int bi;

  initial begin
    tbl[0] = '{32'h0000_0000, 0};
    tbl[1] = '{32'hFFFF_FFFF, 32};
    tbl[2] = '{32'h8000_0001, 2};
    tbl[3] = '{32'h0F0F_0F0F, 16};
    tbl[4] = '{32'h1234_5678, 13};
    tbl[5] = '{32'hAAAA_AAAA, 16};
    tbl[6] = '{32'h0000_0001, 1};
    tbl[7] = '{32'h7FFF_FFFF, 31};
    beats  = '{32'h1, 32'h3, 32'h7, 32'hF, 32'h1F};

    ia.in_valid = 0; ia.in_data = 0; ia.in_mode = 0; ia.in_last = 0; ia.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid_a",  ia.out_valid, 0);
    chk("init_count_a",  ia.out_count, 0);
    chk("init_sat_a",    ia.out_sat,   0);
    chk("init_valid_b",  ib.out_valid, 0);
    chk("init_in_ready", ia.in_ready,  1);
    rst_n = 1'b1;

    // Back-to-back SINGLE beats, out_ready held high: each result exactly 2 cycles later.
    chk_lat = 1;
    for (int k = 0; k < 10; k++) begin
      cyc(k < 8, tbl[(k < 8) ? k : 0].d, 1'b0, 1'b0, 1'b1);
      if (k >= 2) begin
        chk("tbl_valid",   s_ov, 1);
        chk("tbl_count_a", s_ca, tbl[k-2].cnt);
        chk("tbl_count_b", s_cb, tbl[k-2].cnt);
      end
    end
    drain();

    // ACCUM frame of four 0xFF beats.
    for (int k = 0; k < 4; k++) cyc(1'b1, 32'hFF, 1'b1, k == 3, 1'b1);
    drain();

    // Saturating frame on the narrow counter, then a one-beat frame.
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'hFFFF_FFFF, 1'b1, k == 2, 1'b1);
    cyc(1'b1, 32'h1, 1'b1, 1'b1, 1'b1);
    drain();

    // SINGLE beat inside an open ACCUM frame.
    cyc(1'b1, 32'hF, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h3, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'hF, 1'b1, 1'b1, 1'b1);
    drain();

    // Backpressure for 5 cycles with the stream active.
    chk_lat = 0;
    bi = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(bi < 5, beats[(bi < 5) ? bi : 0], 1'b0, 1'b0, 1'b0);
      if (k >= 2) chk("stall_in_ready", s_rdy, 0);
      if (s_fired) bi++;
    end
    chk("accepted_in_stall", bi, 2);
    for (int k = 0; k < 20 && bi < 5; k++) begin
      cyc(1'b1, beats[bi], 1'b0, 1'b0, 1'b1);
      if (s_fired) bi++;
    end
    chk("all_beats_accepted", bi, 5);
    drain();

    // Reset in the middle of a frame while a result is held.
    cyc(1'b1, 32'hFF, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'hFF, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h7,  1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0,  1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0,  1'b0, 1'b0, 1'b0);
    chk("pre_reset_valid", s_ov, 1);
    do_reset();
    cyc(1'b1, 32'h1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h3, 1'b1, 1'b1, 1'b1);
    drain();

    // Randomized traffic with random backpressure and mode mixing.
    for (int k = 0; k < 1500; k++) begin
      logic [31:0] d;
      int sel;
      sel = $urandom_range(0, 7);
      d = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
      cyc($urandom_range(0, 3) != 0, d, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end
    cyc(1'b1, 32'h0, 1'b1, 1'b1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
